// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-addressed memory between the fetch (I) and
// load/store (D) ports; byte and halfword stores are done as read-modify-write.
module mem_arbiter #(
    parameter int MEM_BYTES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    state_t      state;
    logic        last_grant;
    logic        grant_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic        we_q;
    logic [1:0]  size_q;

    logic        pick_d;
    logic [31:0] sel_addr;
    logic        sel_bad;
    logic        fin;
    logic        fin_d;
    logic        fin_err;
    logic        fin_load;

    // last_grant is 1 when D was served last, so a tie goes to I after reset
    always_comb begin
        pick_d   = d_req && (!i_req || !last_grant);
        sel_addr = pick_d ? d_addr : i_addr;
        sel_bad  = sel_addr > MAX_ADDR;
    end

    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_load = 1'b0;
        fin_d    = grant_d;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    fin_d   = pick_d;
                    fin     = sel_bad;
                    fin_err = sel_bad;
                end
            end
            ACCESS: begin
                fin      = !we_q || size_q[1];
                fin_load = !we_q;
            end
            MERGE:   fin = 1'b1;
            default: ;
        endcase
    end

    // Write enable is qualified by reset so an interrupted RMW never reaches memory
    always_comb begin
        mem_we      = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        case (state)
            ACCESS: begin
                mem_address = addr_q;
                if (we_q && size_q[1]) begin
                    mem_we      = reset;
                    mem_data_in = wdata_q;
                end
            end
            MERGE: begin
                mem_address = addr_q;
                mem_we      = reset;
                mem_data_in = size_q[0] ? {old_q[31:16], wdata_q[15:0]}
                                        : {old_q[31:8],  wdata_q[7:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_d    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_err      <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ready <= fin && !fin_d;
            d_ready <= fin && fin_d;
            i_err   <= fin_err && !fin_d;
            d_err   <= fin_err && fin_d;
            if (fin && (fin_load || fin_err)) begin
                if (fin_d)
                    d_rdata <= fin_err ? '0 : mem_data_out;
                else
                    i_rdata <= fin_err ? '0 : mem_data_out;
            end
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_d    <= pick_d;
                        last_grant <= pick_d;
                        addr_q     <= sel_addr;
                        we_q       <= pick_d && d_we;
                        size_q     <= pick_d ? d_size : 2'b10;
                        wdata_q    <= pick_d ? d_wdata : '0;
                        state      <= sel_bad ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (fin) begin
                        state <= DONE;
                    end else begin
                        old_q <= mem_data_out;
                        state <= MERGE;
                    end
                end
                MERGE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory model on the memory port, scoreboard of
// expected responses per port, directed scenarios plus randomized concurrent traffic.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    typedef struct {
        bit  port;
        time t;
    } done_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         we_count = 0;
    exp_t       iq[$];
    exp_t       dq[$];
    done_t      log_q[$];
    logic [7:0] mem [0:63];
    logic [7:0] ref_mem [0:63];

    mem_arbiter #(.MEM_BYTES(64)) dut (
        .clock(clock),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_ready(i_ready),
        .i_rdata(i_rdata),
        .i_err(i_err),
        .d_req(d_req),
        .d_we(d_we),
        .d_size(d_size),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ready(d_ready),
        .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_we(mem_we),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // Byte-addressed memory with combinational little-endian word read
    always_comb begin
        mem_data_out = '0;
        if (mem_address <= 32'd60)
            for (int k = 0; k < 4; k++)
                mem_data_out[8*k +: 8] = mem[int'(mem_address[5:0]) + k];
    end

    always @(posedge clock) begin
        if (mem_we) begin
            we_count <= we_count + 1;
            if (mem_address <= 32'd60)
                for (int k = 0; k < 4; k++)
                    mem[int'(mem_address[5:0]) + k] <= mem_data_in[8*k +: 8];
        end
    end

    function automatic logic [31:0] refWord(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = ref_mem[int'(a[5:0]) + k];
        return w;
    endfunction

    // Reference store: write only the bytes the access size covers
    task automatic refStore(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
        int nb;
        nb = size[1] ? 4 : (size[0] ? 2 : 1);
        for (int k = 0; k < nb; k++)
            ref_mem[int'(a[5:0]) + k] = wd[8*k +: 8];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request on a port, queue its expected response, wait for completion
    task automatic applyStimulus(input bit port, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit keep, input int exp_lat);
        exp_t e;
        int   n;
        logic rdy;
        e.err = addr > 32'd60;
        e.chk = e.err || !we || !port;
        if (!e.err && port && we)
            refStore(addr, size, wdata);
        e.rdata = (e.err || (port && we)) ? 32'h0 : refWord(addr);
        if (port) begin
            dq.push_back(e);
            d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            iq.push_back(e);
            i_addr = addr; i_req = 1'b1;
        end
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            rdy = port ? d_ready : i_ready;
        end
        checkOutput(port ? "d_ready_seen" : "i_ready_seen", 32'(rdy), 32'd1);
        if (exp_lat >= 0)
            checkOutput(port ? "d_latency" : "i_latency", 32'(n), 32'(exp_lat));
        if (!keep) begin
            if (port) d_req = 1'b0; else i_req = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          w0;
        logic [31:0] a;

        // Scoreboard monitor: pops an expected response whenever a port completes
        fork
            begin
                exp_t  e;
                done_t dn;
                forever begin
                    @(negedge clock);
                    if (i_ready === 1'b1) begin
                        if (iq.size() == 0) begin
                            vectors++; miscompares++;
                            $display("[TB] FAIL i_spurious: got i_ready=1, expected 0 (nothing outstanding)");
                        end else begin
                            e = iq.pop_front();
                            checkOutput("i_err", 32'(i_err), 32'(e.err));
                            if (e.chk) checkOutput("i_rdata", i_rdata, e.rdata);
                        end
                        dn.port = 1'b0; dn.t = $time; log_q.push_back(dn);
                    end
                    if (d_ready === 1'b1) begin
                        if (dq.size() == 0) begin
                            vectors++; miscompares++;
                            $display("[TB] FAIL d_spurious: got d_ready=1, expected 0 (nothing outstanding)");
                        end else begin
                            e = dq.pop_front();
                            checkOutput("d_err", 32'(d_err), 32'(e.err));
                            if (e.chk) checkOutput("d_rdata", d_rdata, e.rdata);
                        end
                        dn.port = 1'b1; dn.t = $time; log_q.push_back(dn);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        for (int k = 0; k < 16; k++)
            applyStimulus(1, 1, 2'b10, 32'(4*k), $urandom, 0, 2);
        applyStimulus(0, 0, 2'b10, 32'd0, 32'd0, 0, 2);

        $display("[TB] reset with both requests held");
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'd0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'd36;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            checkOutput("rst_flags", {27'b0, i_ready, d_ready, i_err, d_err, mem_we}, 32'h0);
            checkOutput("rst_i_rdata", i_rdata, 32'h0);
            checkOutput("rst_d_rdata", d_rdata, 32'h0);
        end
        reset = 1'b1;
        log_q.delete();

        $display("[TB] continuous contention");
        fork
            begin
                for (int k = 0; k < 4; k++)
                    applyStimulus(0, 0, 2'b10, (k == 0) ? 32'd0 : 32'($urandom_range(0, 28)),
                                  32'd0, k < 3, (k == 0) ? 2 : -1);
            end
            begin
                for (int k = 0; k < 4; k++)
                    applyStimulus(1, 1'($urandom_range(0, 1)), 2'b10, 32'(32 + 4*$urandom_range(0, 7)),
                                  $urandom, k < 3, -1);
            end
        join
        checkOutput("contention_count", 32'(log_q.size()), 32'd8);
        for (int k = 0; k < log_q.size(); k++) begin
            checkOutput("contention_order", 32'(log_q[k].port), 32'(k % 2));
            if (k > 0)
                checkOutput("contention_gap", 32'(log_q[k].t - log_q[k-1].t), 32'd30);
        end

        $display("[TB] word store / load");
        applyStimulus(1, 1, 2'b10, 32'd8, 32'hDEADBEEF, 0, 2);
        applyStimulus(1, 0, 2'b10, 32'd8, 32'd0, 0, 2);
        checkOutput("word_reload", d_rdata, 32'hDEADBEEF);

        $display("[TB] read-modify-write stores");
        applyStimulus(1, 1, 2'b10, 32'd4, 32'h11223344, 0, 2);
        w0 = we_count;
        applyStimulus(1, 1, 2'b00, 32'd4, 32'h000000AA, 0, 3);
        checkOutput("byte_we_cycles", 32'(we_count - w0), 32'd1);
        applyStimulus(1, 0, 2'b10, 32'd4, 32'd0, 0, 2);
        checkOutput("byte_reload", d_rdata, 32'h112233AA);
        applyStimulus(1, 1, 2'b10, 32'd4, 32'h11223344, 0, 2);
        w0 = we_count;
        applyStimulus(1, 1, 2'b01, 32'd4, 32'h0000BBCC, 0, 3);
        checkOutput("half_we_cycles", 32'(we_count - w0), 32'd1);
        applyStimulus(1, 0, 2'b10, 32'd4, 32'd0, 0, 2);
        checkOutput("half_reload", d_rdata, 32'h1122BBCC);

        $display("[TB] out-of-range accesses");
        w0 = we_count;
        applyStimulus(1, 0, 2'b10, 32'd61, 32'd0, 0, 1);
        applyStimulus(1, 1, 2'b10, 32'd62, 32'hCAFEF00D, 0, 1);
        applyStimulus(0, 0, 2'b10, 32'hFFFFFFFC, 32'd0, 0, 1);
        checkOutput("range_no_write", 32'(we_count - w0), 32'd0);
        applyStimulus(1, 0, 2'b10, 32'd60, 32'd0, 0, 2);

        $display("[TB] reset during MERGE");
        applyStimulus(1, 1, 2'b10, 32'd12, 32'h01020304, 0, 2);
        d_we = 1'b1; d_size = 2'b00; d_addr = 32'd12; d_wdata = 32'h00000055; d_req = 1'b1;
        @(posedge clock);
        #1 d_req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        w0 = we_count;
        @(negedge clock);
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("midrst_d_ready", 32'(d_ready), 32'd0);
        checkOutput("midrst_no_write", 32'(we_count - w0), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(1, 0, 2'b10, 32'd12, 32'd0, 0, 2);
        checkOutput("midrst_reload", d_rdata, 32'h01020304);

        $display("[TB] randomized concurrent traffic");
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    if ($urandom_range(0, 7) == 0)
                        a = 32'(61 + $urandom_range(0, 40));
                    else
                        a = 32'($urandom_range(0, 28));
                    applyStimulus(0, 0, 2'b10, a, 32'd0, 0, -1);
                    repeat ($urandom_range(0, 2)) @(posedge clock);
                    #1;
                end
            end
            begin
                logic we;
                for (int k = 0; k < 30; k++) begin
                    we = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 9) == 0)
                        a = 32'(61 + $urandom_range(0, 200));
                    else if (we)
                        a = 32'($urandom_range(32, 60));
                    else
                        a = 32'($urandom_range(0, 60));
                    applyStimulus(1, we, 2'($urandom_range(0, 3)), a, $urandom, 0, -1);
                    repeat ($urandom_range(0, 2)) @(posedge clock);
                    #1;
                end
            end
        join
        repeat (2) @(posedge clock);
        #1;
        checkOutput("iq_drained", 32'(iq.size()), 32'd0);
        checkOutput("dq_drained", 32'(dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory controller that shares the 64-byte data memory between the instruction-fetch requester (I) and the load/store requester (D). It arbitrates round-robin, sequences each access through a small FSM, and implements byte and halfword stores as read-modify-write, because the memory always writes four bytes. It sits between the core's fetch/LSU stages and the `memory` instance, and drives that instance's `we`/`address`/`data_in`.

## Interface
- `MEM_BYTES`, 64: memory size in bytes. A legal address satisfies addr <= MEM_BYTES-4.
- `clock` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `i_req` input 1: fetch request. Held until `i_ready`.
- `i_addr` input 32: fetch byte address.
- `i_ready` output 1: one-cycle completion pulse. `i_rdata`/`i_err` are valid in this cycle.
- `i_rdata` output 32: fetched word, {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- `i_err` output 1: out-of-range fetch. Pulses together with `i_ready`.
- `d_req` input 1: load/store request. Held until `d_ready`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_size` input 2: 00 byte, 01 half, 10/11 word (stores only).
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data, right-aligned.
- `d_ready` output 1: one-cycle completion pulse.
- `d_rdata` output 32: raw loaded word, unextended. Extension belongs to the LSU.
- `d_err` output 1: out-of-range access. Pulses together with `d_ready`.
- `mem_we` output 1: memory write enable.
- `mem_address` output 32: memory address.
- `mem_data_in` output 32: memory write data.
- `mem_data_out` input 32: memory combinational read data.

## Operation
- **FSM states:** IDLE, ACCESS, MERGE, DONE.
- **IDLE:**
  - If any request is present, grant one, latch its addr/we/size/wdata, and go to ACCESS.
  - If none is present, stay in IDLE.
- **Arbitration:**
  - Both requesting: grant the requester not granted last (`last_grant` toggles).
  - One requesting: grant it.
  - `last_grant` resets to D, so I wins the first tie after reset.
- **Range check (at grant):** if addr > MEM_BYTES-4, go directly to DONE. `err`=1, `rdata`=0, and no `mem_we` is ever issued.
- **ACCESS:**
  - `mem_address` = latched addr.
  - Load/fetch: capture `mem_data_out` into `rdata`, then go to DONE.
  - Word store: `mem_we`=1, `mem_data_in`=wdata, then go to DONE.
  - Byte/half store: capture `mem_data_out` as old word, then go to MERGE.
- **MERGE:**
  - `mem_we`=1, `mem_address`=addr.
  - Byte store: `mem_data_in` = {old[31:8], wdata[7:0]}.
  - Half store: `mem_data_in` = {old[31:16], wdata[15:0]}.
  - Then go to DONE.
- **DONE:**
  - Assert the granted requester's `ready` (and `err` if applicable) for one cycle.
  - `rdata` holds its value until the next completion for that port.
  - Go to IDLE.
- **Misaligned but in-range addresses:** legal. The memory is byte-addressed, so no alignment check is performed.
- **Outside ACCESS/MERGE:** `mem_address` = 0, `mem_data_in` = 0, `mem_we` = 0.
- **`mem_we` gating:** `mem_we` is combinational from state and gated by `reset`. It is 0 in any cycle where `reset`==0.

## Timing
- **Reset:** at a rising edge with `reset`==0:
  - state goes to IDLE and `last_grant` to D;
  - `i_ready`, `d_ready`, `i_err`, `d_err`, `i_rdata`, `d_rdata` go to 0;
  - any in-flight access is abandoned with no ready pulse;
  - a pending RMW write is never issued.
- **Latency:** counted from the edge that grants in IDLE (cycle 0).
  - Load, fetch, word store: `ready` high in cycle 2.
  - Byte/half store: `ready` high in cycle 3.
  - Error: `ready` high in cycle 1.
- **Throughput:** back-to-back accesses cost 3 cycles (word) or 4 cycles (sub-word), because IDLE is always visited between accesses.
- **Handshake:**
  - The requester drops `req` at the edge where it observes `ready`=1.
  - A `req` still high in the following IDLE cycle is served as a new request.
  - Request inputs are ignored outside IDLE. Changing addr/wdata mid-access has no effect.
- **Simultaneous requests:** the loser's `req` stays pending and is granted at its next IDLE. Under continuous contention the two ports strictly alternate.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `i_req`=`d_req`=1. Required: all outputs 0 and `mem_we`=0 throughout. On release, I is granted first and `i_ready` rises 2 cycles after release.
- **Word store then load:** D stores 0xDEADBEEF to addr 8, then loads addr 8. Required: `d_ready` at cycle 2 for each access, and `d_rdata`=0xDEADBEEF.
- **RMW store:** preload addr 4 with 0x11223344, store byte 0xAA, size 00, to addr 4. Required: `mem_we` only in MERGE, `d_ready` at cycle 3, and a reload of addr 4 returns 0x112233AA. Repeat with half 0xBBCC: reload returns 0x1122BBCC.
- **Contention:** hold `i_req` and `d_req` high continuously. Required: grants alternate I, D, I, D with a `ready` every 3 cycles. A fetch of addr 0 returns the memory word at 0.
- **Range error:** load from addr 61 with MEM_BYTES=64. Required: `d_ready`=`d_err`=1 at cycle 1, `d_rdata`=0, `mem_we` never set. A store to addr 62 leaves memory unchanged.
- **Mid-operation reset:** assert `reset`=0 during MERGE of a byte store. Required: no `mem_we` in that cycle, no `d_ready` pulse, and a reload shows the old word unchanged.
